control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the 8-bit bus computer; sits directly downstream of the instruction register and consumes its 4-bit opcode. A stage counter steps through fetch (T0–T1) and execute (T2–T4) stages, ending each instruction early when its microcode is done. It emits the active-low load/enable strobes that move data between PC, MAR, RAM, IR, A, B, ALU and output registers over the shared bus.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- n_clear  in  1  asynchronous active-low reset
- opcode  in  4  instruction opcode from instruction register (valid from T2)
- carry_flag  in  1  registered ALU carry flag
- zero_flag  in  1  registered ALU zero flag
- stage  out  3  current stage: 0–4 = T0–T4, 7 = HALT
- pc_inc  out  1  increment program counter
- n_pc_enable / n_pc_load  out  1 each  PC drives bus / PC loads from bus
- n_mar_load  out  1  MAR loads from bus
- n_ram_enable  out  1  RAM drives bus; ram_write  out  1  RAM writes bus at MAR
- n_ir_load / n_ir_enable  out  1 each  IR loads bus / IR drives operand nibble
- n_a_load / n_a_enable  out  1 each  accumulator load / drive
- n_b_load  out  1  B register load
- n_alu_enable  out  1  ALU result drives bus; sub  out  1  ALU subtracts
- flags_load  out  1  flag register captures ALU carry/zero
- n_out_load  out  1  output register load
- halt  out  1  processor halted

## Operation
- Outputs are pure decode of registered stage, opcode and flags; inactive unless listed (n_* high, others low).
- T0: n_pc_enable, n_mar_load. T1: n_ram_enable, n_ir_load, pc_inc.
- Opcodes (execute stages; "end" = next stage T0):
  - 0001 LDA: T2 n_ir_enable, n_mar_load; T3 n_ram_enable, n_a_load; end.
  - 0010 ADD: T2 n_ir_enable, n_mar_load; T3 n_ram_enable, n_b_load; T4 n_alu_enable, n_a_load, flags_load; end.
  - 0011 SUB: as ADD, plus sub=1 in T3 and T4.
  - 0100 STA: T2 n_ir_enable, n_mar_load; T3 n_a_enable, ram_write; end.
  - 0101 LDI: T2 n_ir_enable, n_a_load; end.
  - 0110 JMP: T2 n_ir_enable, n_pc_load; end.
  - 0111 JC / 1000 JZ: T2 as JMP if carry_flag / zero_flag is 1, else nothing; end.
  - 1110 OUT: T2 n_a_enable, n_out_load; end.
  - 1111 HLT: T2 halt=1; next stage HALT.
  - 0000 NOP and undefined 1001–1101: T2 nothing; end.
- HALT: halt=1, all other strobes inactive; remains until n_clear asserted.
- Invariant: at most one of n_pc_enable, n_ram_enable, n_ir_enable, n_a_enable, n_alu_enable low in any cycle.
- Invariant: ram_write never high in the same cycle as n_ram_enable low.

## Timing
- n_clear low: stage=0 immediately (async); every output forced inactive (n_* =1, pc_inc/ram_write/sub/flags_load/halt =0) for the whole reset period, including T0 strobes.
- First rising edge after n_clear deasserts: T0 strobes active that cycle; stage advances to 1 at that edge.
- Strobes asserted during stage k are sampled by datapath registers on the rising edge ending stage k; the same edge advances stage.
- Instruction lengths (cycles, incl. fetch): LDI/JMP/JC/JZ/OUT/NOP/undefined 3, LDA/STA 4, ADD/SUB 5; HLT reaches HALT after 3.
- Conditional jumps sample flags combinationally during T2 only; flag changes in other stages have no effect.
- Stage never exceeds 4; no wrap from T4 other than to T0.
- n_clear asserted mid-instruction or in HALT: abort immediately; restart at T0.

## Test plan
- Reset: hold n_clear low 3 cycles -> stage=0, all n_* =1, all active-high outputs 0; first cycle after release shows n_pc_enable=0, n_mar_load=0.
- LDA (0001): stage sequence 0,1,2,3,0; T1 shows n_ir_load=0 and pc_inc=1; T3 shows n_ram_enable=0, n_a_load=0.
- SUB (0011): 5-cycle sequence; T4 shows n_alu_enable=0, n_a_load=0, flags_load=1, sub=1; ADD (0010) identical with sub=0.
- JC (0111) with carry_flag=1 -> T2 n_ir_enable=0, n_pc_load=0; with carry_flag=0 -> no strobes, stage returns to 0 after T2; repeat for JZ with zero_flag.
- HLT (1111): stage reaches 7, halt=1 held for 20 cycles with no strobes; n_clear pulse -> stage=0, halt=0.
- Reset in ADD T3 -> outputs inactive immediately, stage=0; undefined opcode 1010 -> 3-cycle no-op; bus-driver exclusivity checked every cycle of all runs.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bundle of opcode/flag inputs and bus strobes between the control sequencer
// (master) and the 8-bit datapath (slave).
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic [2:0] stage;
    logic       pc_inc;
    logic       n_pc_enable;
    logic       n_pc_load;
    logic       n_mar_load;
    logic       n_ram_enable;
    logic       ram_write;
    logic       n_ir_load;
    logic       n_ir_enable;
    logic       n_a_load;
    logic       n_a_enable;
    logic       n_b_load;
    logic       n_alu_enable;
    logic       sub;
    logic       flags_load;
    logic       n_out_load;
    logic       halt;

    modport master (
        input  opcode, carry_flag, zero_flag,
        output stage, pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable,
               ram_write, n_ir_load, n_ir_enable, n_a_load, n_a_enable, n_b_load,
               n_alu_enable, sub, flags_load, n_out_load, halt
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  stage, pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable,
               ram_write, n_ir_load, n_ir_enable, n_a_load, n_a_enable, n_b_load,
               n_alu_enable, sub, flags_load, n_out_load, halt
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded stage sequencer for the 8-bit bus computer: fetch in T0-T1,
// opcode-dependent execute in T2-T4, strobes decoded from the stage register.
module control_sequencer (
    input  logic                clk,
    input  logic                n_clear,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } stage_e;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    stage_e state;
    logic   is_arith;

    assign is_arith = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; combinational decode below uses blocking assignments.
    always_ff @(posedge clk or negedge n_clear) begin
        if (!n_clear) begin
            state <= T0;
        end else begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: state <= T3;
                        OP_HLT:                         state <= HALT;
                        default:                        state <= T0;
                    endcase
                end
                T3:      state <= is_arith ? T4 : T0;
                T4:      state <= T0;
                HALT:    state <= HALT;
                default: state <= T0;
            endcase
        end
    end

    // NOTE: n_clear gates the decode directly so T0 strobes stay inactive for
    // the whole reset period even though the stage register already reads T0.
    always_comb begin
        bus.stage        = state;
        bus.pc_inc       = 1'b0;
        bus.n_pc_enable  = 1'b1;
        bus.n_pc_load    = 1'b1;
        bus.n_mar_load   = 1'b1;
        bus.n_ram_enable = 1'b1;
        bus.ram_write    = 1'b0;
        bus.n_ir_load    = 1'b1;
        bus.n_ir_enable  = 1'b1;
        bus.n_a_load     = 1'b1;
        bus.n_a_enable   = 1'b1;
        bus.n_b_load     = 1'b1;
        bus.n_alu_enable = 1'b1;
        bus.sub          = 1'b0;
        bus.flags_load   = 1'b0;
        bus.n_out_load   = 1'b1;
        bus.halt         = 1'b0;
        if (n_clear) begin
            case (state)
                T0: begin
                    bus.n_pc_enable = 1'b0;
                    bus.n_mar_load  = 1'b0;
                end
                T1: begin
                    bus.n_ram_enable = 1'b0;
                    bus.n_ir_load    = 1'b0;
                    bus.pc_inc       = 1'b1;
                end
                T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            bus.n_ir_enable = 1'b0;
                            bus.n_mar_load  = 1'b0;
                        end
                        OP_LDI: begin
                            bus.n_ir_enable = 1'b0;
                            bus.n_a_load    = 1'b0;
                        end
                        OP_JMP: begin
                            bus.n_ir_enable = 1'b0;
                            bus.n_pc_load   = 1'b0;
                        end
                        // Conditional jumps look at the flags only in this stage.
                        OP_JC, OP_JZ: begin
                            if ((bus.opcode == OP_JC) ? bus.carry_flag : bus.zero_flag) begin
                                bus.n_ir_enable = 1'b0;
                                bus.n_pc_load   = 1'b0;
                            end
                        end
                        OP_OUT: begin
                            bus.n_a_enable = 1'b0;
                            bus.n_out_load = 1'b0;
                        end
                        OP_HLT:  bus.halt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            bus.n_ram_enable = 1'b0;
                            bus.n_a_load     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.n_ram_enable = 1'b0;
                            bus.n_b_load     = 1'b0;
                            bus.sub          = (bus.opcode == OP_SUB);
                        end
                        OP_STA: begin
                            bus.n_a_enable = 1'b0;
                            bus.ram_write  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (is_arith) begin
                        bus.n_alu_enable = 1'b0;
                        bus.n_a_load     = 1'b0;
                        bus.flags_load   = 1'b1;
                        bus.sub          = (bus.opcode == OP_SUB);
                    end
                end
                HALT:    bus.halt = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class stage by
// stage and compares stage number and the full strobe vector to hand values.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic n_clear = 1'b0;
    int   checks = 0;
    int   errors = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk     (clk),
        .n_clear (n_clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable, ram_write,
    //  n_ir_load, n_ir_enable, n_a_load, n_a_enable, n_b_load, n_alu_enable,
    //  sub, flags_load, n_out_load, halt}
    logic [15:0] strobes;
    assign strobes = {bus.pc_inc, bus.n_pc_enable, bus.n_pc_load, bus.n_mar_load,
                      bus.n_ram_enable, bus.ram_write, bus.n_ir_load, bus.n_ir_enable,
                      bus.n_a_load, bus.n_a_enable, bus.n_b_load, bus.n_alu_enable,
                      bus.sub, bus.flags_load, bus.n_out_load, bus.halt};

    localparam logic [15:0] INACTIVE = 16'h7BF2;
    localparam logic [15:0] S_PC_INC = 16'h8000;
    localparam logic [15:0] S_PC_EN  = 16'h4000;
    localparam logic [15:0] S_PC_LD  = 16'h2000;
    localparam logic [15:0] S_MAR_LD = 16'h1000;
    localparam logic [15:0] S_RAM_EN = 16'h0800;
    localparam logic [15:0] S_RAM_WR = 16'h0400;
    localparam logic [15:0] S_IR_LD  = 16'h0200;
    localparam logic [15:0] S_IR_EN  = 16'h0100;
    localparam logic [15:0] S_A_LD   = 16'h0080;
    localparam logic [15:0] S_A_EN   = 16'h0040;
    localparam logic [15:0] S_B_LD   = 16'h0020;
    localparam logic [15:0] S_ALU_EN = 16'h0010;
    localparam logic [15:0] S_SUB    = 16'h0008;
    localparam logic [15:0] S_FLAGS  = 16'h0004;
    localparam logic [15:0] S_OUT_LD = 16'h0002;
    localparam logic [15:0] S_HALT   = 16'h0001;
    localparam logic [15:0] M_T0     = S_PC_EN | S_MAR_LD;
    localparam logic [15:0] M_T1     = S_RAM_EN | S_IR_LD | S_PC_INC;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stage, strobes (active bits given as a mask), and both bus invariants.
    task automatic chk(input string tag, input logic [2:0] st, input logic [15:0] mask);
        logic [4:0] drv;
        logic       bad;
        check({tag, ".stage"}, {13'b0, bus.stage}, {13'b0, st});
        check({tag, ".strobes"}, strobes, INACTIVE ^ mask);
        drv = {strobes[14], strobes[11], strobes[8], strobes[6], strobes[4]};
        bad = ($countones(~drv) > 1) || (strobes[10] && !strobes[11]);
        check({tag, ".invariant"}, {15'b0, bad}, 16'h0000);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Checks T0 and T1 at the current point, presents the opcode, lands in T2.
    task automatic fetch(input string tag, input logic [3:0] op);
        chk({tag, ".t0"}, 3'd0, M_T0);
        cyc();
        chk({tag, ".t1"}, 3'd1, M_T1);
        bus.opcode = op;
        cyc();
    endtask

    initial begin
        bus.opcode     = 4'b0000;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;

        // Reset held three cycles: everything inactive.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset", 3'd0, 16'h0000);
        end
        n_clear = 1'b1;
        #1;

        // LDA: 0,1,2,3,0
        fetch("lda", 4'b0001);
        chk("lda.t2", 3'd2, S_IR_EN | S_MAR_LD);
        cyc();
        chk("lda.t3", 3'd3, S_RAM_EN | S_A_LD);
        cyc();

        // ADD: five cycles, sub low
        fetch("add", 4'b0010);
        chk("add.t2", 3'd2, S_IR_EN | S_MAR_LD);
        cyc();
        chk("add.t3", 3'd3, S_RAM_EN | S_B_LD);
        cyc();
        chk("add.t4", 3'd4, S_ALU_EN | S_A_LD | S_FLAGS);
        cyc();

        // SUB: as ADD with sub in T3 and T4
        fetch("sub", 4'b0011);
        chk("sub.t2", 3'd2, S_IR_EN | S_MAR_LD);
        cyc();
        chk("sub.t3", 3'd3, S_RAM_EN | S_B_LD | S_SUB);
        cyc();
        chk("sub.t4", 3'd4, S_ALU_EN | S_A_LD | S_FLAGS | S_SUB);
        cyc();

        fetch("sta", 4'b0100);
        chk("sta.t2", 3'd2, S_IR_EN | S_MAR_LD);
        cyc();
        chk("sta.t3", 3'd3, S_A_EN | S_RAM_WR);
        cyc();

        fetch("ldi", 4'b0101);
        chk("ldi.t2", 3'd2, S_IR_EN | S_A_LD);
        cyc();

        fetch("jmp", 4'b0110);
        chk("jmp.t2", 3'd2, S_IR_EN | S_PC_LD);
        cyc();

        // Conditional jumps: right flag taken, wrong flag ignored.
        bus.carry_flag = 1'b1;
        fetch("jc_taken", 4'b0111);
        chk("jc_taken.t2", 3'd2, S_IR_EN | S_PC_LD);
        cyc();
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b1;
        fetch("jc_not", 4'b0111);
        chk("jc_not.t2", 3'd2, 16'h0000);
        cyc();
        fetch("jz_taken", 4'b1000);
        chk("jz_taken.t2", 3'd2, S_IR_EN | S_PC_LD);
        cyc();
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b1;
        fetch("jz_not", 4'b1000);
        chk("jz_not.t2", 3'd2, 16'h0000);
        cyc();
        bus.carry_flag = 1'b0;

        fetch("out", 4'b1110);
        chk("out.t2", 3'd2, S_A_EN | S_OUT_LD);
        cyc();

        fetch("nop", 4'b0000);
        chk("nop.t2", 3'd2, 16'h0000);
        cyc();

        fetch("undef", 4'b1010);
        chk("undef.t2", 3'd2, 16'h0000);
        cyc();

        // Reset during ADD T3 aborts at once and holds T0 inactive.
        fetch("add_rst", 4'b0010);
        chk("add_rst.t2", 3'd2, S_IR_EN | S_MAR_LD);
        cyc();
        chk("add_rst.t3", 3'd3, S_RAM_EN | S_B_LD);
        #2;
        n_clear = 1'b0;
        #1;
        chk("mid_reset", 3'd0, 16'h0000);
        cyc();
        chk("mid_reset_held", 3'd0, 16'h0000);
        n_clear = 1'b1;
        #1;

        // HLT: halt in T2, then HALT stage sticks with only halt asserted.
        fetch("hlt", 4'b1111);
        chk("hlt.t2", 3'd2, S_HALT);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halted", 3'd7, S_HALT);
        end
        #2;
        n_clear = 1'b0;
        #1;
        chk("halt_clear", 3'd0, 16'h0000);
        n_clear = 1'b1;
        bus.opcode = 4'b0000;
        #1;
        chk("restart.t0", 3'd0, M_T0);
        cyc();
        chk("restart.t1", 3'd1, M_T1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
